// File: rtl/redux_v_pkg.sv
// Shared Redux-V definitions used by the fetch stage and its neighbours.
//  - opcode constants for the two control-flow instructions
//  - bit positions of the IR fields
//  - fetch FSM state encoding
package redux_v_pkg;

  localparam logic [3:0] OP_BRZR = 4'b0000;
  localparam logic [3:0] OP_JI   = 4'b0001;

  // IR field positions: [7:4] opcode, [3:2] ra, [1:0] rb, [3:0] imm
  localparam int IR_OP_HI  = 7;
  localparam int IR_OP_LO  = 4;
  localparam int IR_RA_HI  = 3;
  localparam int IR_RA_LO  = 2;
  localparam int IR_RB_HI  = 1;
  localparam int IR_RB_LO  = 0;
  localparam int IR_IMM_HI = 3;
  localparam int IR_IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction-memory fetch bus.
//  imem_req  : fetch side -> memory, request pending
//  imem_addr : fetch side -> memory, address (held with imem_req)
//  imem_ack  : memory -> fetch side, imem_data valid this cycle
//  imem_data : memory -> fetch side, instruction
// Handshake: imem_req and imem_addr stay stable from the cycle imem_req
// rises until the cycle imem_ack is sampled high with imem_req high; that
// cycle completes the transfer. imem_ack without imem_req carries nothing.
interface busca_instrucao_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/pc_proximo.sv
// Next-PC computation for the fetch stage (purely combinational).
//  pc       : address of the instruction currently in the IR
//  imm      : 4-bit two's-complement jump offset (ji)
//  b_mx     : current instruction is brzr
//  j_mx     : current instruction is ji (takes priority over b_mx)
//  zero     : R[ra] == 0
//  rb_value : brzr target
//  next_pc  : address to fetch after the current instruction
// All arithmetic wraps modulo 2^PC_W.
module pc_proximo #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [3:0]      imm,
  input  logic            b_mx,
  input  logic            j_mx,
  input  logic            zero,
  input  logic [PC_W-1:0] rb_value,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] imm_ext;

  assign imm_ext = {{(PC_W-4){imm[3]}}, imm};

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (j_mx) begin
      next_pc = pc + imm_ext;
    end else if (b_mx && zero) begin
      next_pc = rb_value;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage of the Redux-V core.
// Holds the PC, fetches one instruction at a time over the imem bus,
// latches it in the IR and presents its fields to decode. When execute
// accepts the instruction, the PC advances to next_pc and the next fetch
// starts.
//  clk, rst     : clock, asynchronous active-high reset
//  imem         : instruction-memory bus (master side)
//  instr_valid  : IR holds an instruction for decode/execute
//  instr_accept : execute is done with the IR
//  opcode/ra/rb/imm : IR fields
//  b_mx, j_mx, zero, rb_value : control and register-file inputs for next_pc
//  pc           : address of the instruction in the IR
//  fetch_state  : current FSM state (debug)
// Handshake on instr_valid/instr_accept: the IR and pc are stable while
// instr_valid is high; a cycle with both high retires the instruction.
module busca_instrucao
  import redux_v_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int          INSTR_W  = 8,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  busca_instrucao_if.master   imem,
  output logic                instr_valid,
  input  logic                instr_accept,
  output logic [3:0]          opcode,
  output logic [1:0]          ra,
  output logic [1:0]          rb,
  output logic [3:0]          imm,
  input  logic                b_mx,
  input  logic                j_mx,
  input  logic                zero,
  input  logic [PC_W-1:0]     rb_value,
  output logic [PC_W-1:0]     pc,
  output fetch_state_t        fetch_state
);

  fetch_state_t       state;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    next_pc;

  pc_proximo #(.PC_W(PC_W)) u_pc_proximo (
    .pc       (pc_q),
    .imm      (ir[IR_IMM_HI:IR_IMM_LO]),
    .b_mx     (b_mx),
    .j_mx     (j_mx),
    .zero     (zero),
    .rb_value (rb_value),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc_q  <= PC_W'(RESET_PC);
      ir    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          // Ack in the first FETCH cycle is legal: one-cycle fetch.
          if (imem.imem_ack) begin
            ir    <= imem.imem_data;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_accept) begin
            pc_q  <= next_pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request and valid are pure decodes of the state register, so reset
  // clears them in the same cycle it is asserted.
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state == ISSUE);

  assign opcode      = ir[IR_OP_HI:IR_OP_LO];
  assign ra          = ir[IR_RA_HI:IR_RA_LO];
  assign rb          = ir[IR_RB_HI:IR_RB_LO];
  assign imm         = ir[IR_IMM_HI:IR_IMM_LO];
  assign pc          = pc_q;
  assign fetch_state = state;

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;
  import redux_v_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  busca_instrucao_if #(.PC_W(8), .INSTR_W(8)) imem ();

  logic         instr_valid;
  logic         instr_accept;
  logic [3:0]   opcode;
  logic [1:0]   ra;
  logic [1:0]   rb;
  logic [3:0]   imm;
  logic         b_mx;
  logic         j_mx;
  logic         zero;
  logic [7:0]   rb_value;
  logic [7:0]   pc;
  fetch_state_t fetch_state;

  busca_instrucao #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .opcode       (opcode),
    .ra           (ra),
    .rb           (rb),
    .imm          (imm),
    .b_mx         (b_mx),
    .j_mx         (j_mx),
    .zero         (zero),
    .rb_value     (rb_value),
    .pc           (pc),
    .fetch_state  (fetch_state)
  );

  int tests;
  int fails;

  // ---------------- driver tasks (no checking) ----------------
  // Called at a negedge. Waits (bounded) for imem_req, holds off the ack
  // for lat cycles while recording whether req/addr stayed stable, then
  // acks with data. Returns at the negedge after the ack was sampled.
  task automatic fetch_do(input logic [7:0] data, input int lat,
                          output bit ok, output bit held);
    logic [7:0] addr0;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (imem.imem_req === 1'b1) break;
      @(negedge clk);
    end
    ok = (imem.imem_req === 1'b1);
    if (ok) begin
      addr0 = imem.imem_addr;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== addr0) held = 1'b0;
      end
      imem.imem_ack  = 1'b1;
      imem.imem_data = data;
      @(negedge clk);
      imem.imem_ack  = 1'b0;
      imem.imem_data = 8'h00;
    end
  endtask

  // Called at a negedge in ISSUE: presents control inputs with accept for
  // one cycle, then returns at the next negedge with controls cleared.
  task automatic issue_do(input logic j, input logic b, input logic z,
                          input logic [7:0] rbv);
    j_mx         = j;
    b_mx         = b;
    zero         = z;
    rb_value     = rbv;
    instr_accept = 1'b1;
    @(negedge clk);
    instr_accept = 1'b0;
    j_mx         = 1'b0;
    b_mx         = 1'b0;
    zero         = 1'b0;
    rb_value     = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b valid=%b, want 0 0", imem.imem_req, instr_valid);
    end
    tests++;
    if (pc !== 8'h00 || opcode !== 4'h0 || imm !== 4'h0) begin
      fails++;
      $display("FAIL reset_regs: pc=%h op=%h imm=%h, want 00 0 0", pc, opcode, imm);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (imem.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_release: req=%b, want 0", imem.imem_req);
    end
    @(negedge clk);
    tests++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 8'h00) begin
      fails++;
      $display("FAIL first_fetch: req=%b addr=%h, want 1 00", imem.imem_req, imem.imem_addr);
    end
  endtask

  task automatic test_sequential();
    bit ok, held;
    // 0x40 at 0x00, immediate ack
    fetch_do(8'h40, 0, ok, held);
    tests++;
    if (!ok || instr_valid !== 1'b1 || opcode !== 4'h4 || ra !== 2'd0 || rb !== 2'd0 || pc !== 8'h00) begin
      fails++;
      $display("FAIL ir_40: ok=%b valid=%b op=%h ra=%0d rb=%0d pc=%h, want 1 1 4 0 0 00",
               ok, instr_valid, opcode, ra, rb, pc);
    end
    // ack while in ISSUE must not touch the IR
    imem.imem_ack  = 1'b1;
    imem.imem_data = 8'hAA;
    @(negedge clk);
    imem.imem_ack  = 1'b0;
    imem.imem_data = 8'h00;
    tests++;
    if (instr_valid !== 1'b1 || opcode !== 4'h4 || imm !== 4'h0) begin
      fails++;
      $display("FAIL ack_in_issue: valid=%b op=%h imm=%h, want 1 4 0", instr_valid, opcode, imm);
    end
    issue_do(1'b0, 1'b0, 1'b0, 8'h00);
    tests++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 8'h01) begin
      fails++;
      $display("FAIL addr_1: req=%b addr=%h, want 1 01", imem.imem_req, imem.imem_addr);
    end
    // accept while in FETCH must not advance the PC
    instr_accept = 1'b1;
    @(negedge clk);
    instr_accept = 1'b0;
    tests++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 8'h01 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL accept_in_fetch: req=%b addr=%h valid=%b, want 1 01 0",
               imem.imem_req, imem.imem_addr, instr_valid);
    end
    // 0x51 at 0x01 with 3-cycle ack latency
    fetch_do(8'h51, 3, ok, held);
    tests++;
    if (!ok || !held) begin
      fails++;
      $display("FAIL req_held: ok=%b held=%b, want 1 1", ok, held);
    end
    tests++;
    if (opcode !== 4'h5 || ra !== 2'd0 || rb !== 2'd1 || imm !== 4'h1 || pc !== 8'h01) begin
      fails++;
      $display("FAIL ir_51: op=%h ra=%0d rb=%0d imm=%h pc=%h, want 5 0 1 1 01", opcode, ra, rb, imm, pc);
    end
    issue_do(1'b0, 1'b0, 1'b0, 8'h00);
    tests++;
    if (imem.imem_addr !== 8'h02) begin
      fails++;
      $display("FAIL addr_2: addr=%h, want 02", imem.imem_addr);
    end
    fetch_do(8'h62, 0, ok, held);
    tests++;
    if (!ok || opcode !== 4'h6 || rb !== 2'd2 || imm !== 4'h2 || pc !== 8'h02) begin
      fails++;
      $display("FAIL ir_62: ok=%b op=%h rb=%0d imm=%h pc=%h, want 1 6 2 2 02", ok, opcode, rb, imm, pc);
    end
    issue_do(1'b0, 1'b0, 1'b0, 8'h00);
    tests++;
    if (imem.imem_addr !== 8'h03) begin
      fails++;
      $display("FAIL addr_3: addr=%h, want 03", imem.imem_addr);
    end
  endtask

  task automatic test_ji();
    bit ok, held;
    // ji +2 at 0x03 -> 0x05
    fetch_do(8'h12, 0, ok, held);
    issue_do(1'b1, 1'b0, 1'b0, 8'h00);
    tests++;
    if (imem.imem_addr !== 8'h05) begin
      fails++;
      $display("FAIL ji_fwd: addr=%h, want 05", imem.imem_addr);
    end
    // ji -2 at 0x05 -> 0x03
    fetch_do(8'h1E, 0, ok, held);
    tests++;
    if (!ok || opcode !== OP_JI || ra !== 2'd3 || rb !== 2'd2 || imm !== 4'hE || pc !== 8'h05) begin
      fails++;
      $display("FAIL ir_1e: ok=%b op=%h ra=%0d rb=%0d imm=%h pc=%h, want 1 1 3 2 e 05",
               ok, opcode, ra, rb, imm, pc);
    end
    issue_do(1'b1, 1'b0, 1'b0, 8'h00);
    tests++;
    if (imem.imem_addr !== 8'h03) begin
      fails++;
      $display("FAIL ji_back: addr=%h, want 03", imem.imem_addr);
    end
  endtask

  task automatic test_brzr();
    bit ok, held;
    // brzr taken 0x03 -> 0x10
    fetch_do(8'h00, 0, ok, held);
    issue_do(1'b0, 1'b1, 1'b1, 8'h10);
    tests++;
    if (imem.imem_addr !== 8'h10) begin
      fails++;
      $display("FAIL brzr_to_10: addr=%h, want 10", imem.imem_addr);
    end
    // brzr taken at 0x10, target 0x40
    fetch_do(8'h03, 0, ok, held);
    issue_do(1'b0, 1'b1, 1'b1, 8'h40);
    tests++;
    if (imem.imem_addr !== 8'h40) begin
      fails++;
      $display("FAIL brzr_taken: addr=%h, want 40", imem.imem_addr);
    end
    fetch_do(8'h00, 0, ok, held);
    issue_do(1'b0, 1'b1, 1'b1, 8'h10);
    // brzr not taken at 0x10 -> 0x11
    fetch_do(8'h03, 0, ok, held);
    tests++;
    if (pc !== 8'h10) begin
      fails++;
      $display("FAIL brzr_pc: pc=%h, want 10", pc);
    end
    issue_do(1'b0, 1'b1, 1'b0, 8'h40);
    tests++;
    if (imem.imem_addr !== 8'h11) begin
      fails++;
      $display("FAIL brzr_not_taken: addr=%h, want 11", imem.imem_addr);
    end
    // j_mx and b_mx both set: ji +3 wins over brzr to 0x80
    fetch_do(8'h13, 0, ok, held);
    issue_do(1'b1, 1'b1, 1'b1, 8'h80);
    tests++;
    if (imem.imem_addr !== 8'h14) begin
      fails++;
      $display("FAIL j_priority: addr=%h, want 14", imem.imem_addr);
    end
  endtask

  task automatic test_wrap();
    bit ok, held;
    fetch_do(8'h00, 0, ok, held);
    issue_do(1'b0, 1'b1, 1'b1, 8'hFF);
    fetch_do(8'h70, 0, ok, held);
    tests++;
    if (pc !== 8'hFF || opcode !== 4'h7) begin
      fails++;
      $display("FAIL pc_ff: pc=%h op=%h, want ff 7", pc, opcode);
    end
    issue_do(1'b0, 1'b0, 1'b0, 8'h00);
    tests++;
    if (imem.imem_addr !== 8'h00) begin
      fails++;
      $display("FAIL wrap_inc: addr=%h, want 00", imem.imem_addr);
    end
    // 0x00 -> 0x01 -> 0x02, then ji -4 wraps to 0xFE
    fetch_do(8'h70, 0, ok, held);
    issue_do(1'b0, 1'b0, 1'b0, 8'h00);
    fetch_do(8'h70, 0, ok, held);
    issue_do(1'b0, 1'b0, 1'b0, 8'h00);
    fetch_do(8'h1C, 0, ok, held);
    issue_do(1'b1, 1'b0, 1'b0, 8'h00);
    tests++;
    if (imem.imem_addr !== 8'hFE) begin
      fails++;
      $display("FAIL wrap_ji: addr=%h, want fe", imem.imem_addr);
    end
  endtask

  task automatic test_reset_abort();
    bit ok, held;
    fetch_do(8'h00, 0, ok, held);
    issue_do(1'b0, 1'b1, 1'b1, 8'h07);
    repeat (2) @(negedge clk);
    tests++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 8'h07) begin
      fails++;
      $display("FAIL wait_at_07: req=%b addr=%h, want 1 07", imem.imem_req, imem.imem_addr);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_fetch: req=%b valid=%b pc=%h, want 0 0 00", imem.imem_req, instr_valid, pc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 8'h00) begin
      fails++;
      $display("FAIL refetch_after_fetch_abort: req=%b addr=%h, want 1 00", imem.imem_req, imem.imem_addr);
    end
    // reset while the IR is being issued
    fetch_do(8'h5B, 0, ok, held);
    tests++;
    if (!ok || instr_valid !== 1'b1 || opcode !== 4'h5) begin
      fails++;
      $display("FAIL ir_5b: ok=%b valid=%b op=%h, want 1 1 5", ok, instr_valid, opcode);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (instr_valid !== 1'b0 || opcode !== 4'h0 || imm !== 4'h0) begin
      fails++;
      $display("FAIL rst_mid_issue: valid=%b op=%h imm=%h, want 0 0 0", instr_valid, opcode, imm);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== 8'h00) begin
      fails++;
      $display("FAIL refetch_after_issue_abort: req=%b addr=%h, want 1 00", imem.imem_req, imem.imem_addr);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests          = 0;
    fails          = 0;
    rst            = 1'b1;
    imem.imem_ack  = 1'b0;
    imem.imem_data = 8'h00;
    instr_accept   = 1'b0;
    b_mx           = 1'b0;
    j_mx           = 1'b0;
    zero           = 1'b0;
    rb_value       = 8'h00;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_ji();
    test_brzr();
    test_wrap();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
